// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IF/MEM memory-port arbiter: FSM states, grant owner
// and the round-robin tie-break helper.
`timescale 1ns/1ps
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_IF_BUSY   = 2'd1,
        ARB_DATA_BUSY = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_IF  = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    localparam logic [3:0] BYTE_SEL_ALL = 4'hF;

    // MEM has priority; IF only wins a tie when MEM was served last.
    function automatic logic mem_wins(input logic if_elig, input logic mem_elig,
                                      input grant_e last_grant);
        return mem_elig && !(if_elig && (last_grant == GRANT_MEM));
    endfunction

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// Bus watchdog: counts busy cycles and flags the cycle in which the
// TIMEOUT-th busy cycle passes without completion. TIMEOUT = 0 disables it.
`timescale 1ns/1ps
module arb_watchdog #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST_BUSY = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] count_q;
    logic [TO_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (TIMEOUT != 0) && run && (count_q == LAST_BUSY);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one external memory port between instruction fetch and the MEM
// stage; serialises accesses, holds each command until bus_ack_i, aborts hung ones.
`timescale 1ns/1ps
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ack_o,
    output logic        stallreq_if_o,
    input  logic        flush_i,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ack_o,
    output logic        stallreq_mem_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o
);

    arb_state_e  state_q,      state_d;
    grant_e      last_grant_q, last_grant_d;
    logic        discard_q,    discard_d;
    logic        bus_req_q,    bus_req_d;
    logic        bus_we_q,     bus_we_d;
    logic [3:0]  bus_sel_q,    bus_sel_d;
    logic [31:0] bus_addr_q,   bus_addr_d;
    logic [31:0] bus_wdata_q,  bus_wdata_d;
    logic        bus_err_q,    bus_err_d;
    logic        if_ack_q,     if_ack_d;
    logic [31:0] if_rdata_q,   if_rdata_d;
    logic        mem_ack_q,    mem_ack_d;
    logic [31:0] mem_rdata_q,  mem_rdata_d;

    logic if_elig;
    logic mem_elig;
    logic discard_now;
    logic expired;
    logic access_end;

    // A requester whose ack is still showing has just been served; skip it.
    assign if_elig     = if_req_i  & ~if_ack_q;
    assign mem_elig    = mem_req_i & ~mem_ack_q;
    assign discard_now = discard_q | flush_i;
    assign access_end  = bus_ack_i | expired;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == ARB_IDLE),
        .run     (state_q != ARB_IDLE),
        .expired (expired)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d      = state_q;
        last_grant_d = last_grant_q;
        discard_d    = discard_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_sel_d    = bus_sel_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_err_d    = 1'b0;
        if_ack_d     = 1'b0;
        if_rdata_d   = if_rdata_q;
        mem_ack_d    = 1'b0;
        mem_rdata_d  = mem_rdata_q;

        case (state_q)
            ARB_IDLE: begin
                if (mem_wins(if_elig, mem_elig, last_grant_q)) begin
                    state_d      = ARB_DATA_BUSY;
                    last_grant_d = GRANT_MEM;
                    bus_req_d    = 1'b1;
                    bus_we_d     = mem_we_i;
                    bus_sel_d    = mem_sel_i;
                    bus_addr_d   = mem_addr_i;
                    bus_wdata_d  = mem_wdata_i;
                end else if (if_elig) begin
                    state_d      = ARB_IF_BUSY;
                    last_grant_d = GRANT_IF;
                    bus_req_d    = 1'b1;
                    bus_we_d     = 1'b0;
                    bus_sel_d    = BYTE_SEL_ALL;
                    bus_addr_d   = if_addr_i;
                    bus_wdata_d  = '0;
                end
            end

            ARB_IF_BUSY: begin
                if (flush_i) begin
                    discard_d = 1'b1;
                end
                // An ack arriving together with expiry wins, so no error is raised.
                if (access_end) begin
                    state_d   = ARB_IDLE;
                    bus_req_d = 1'b0;
                    bus_err_d = ~bus_ack_i;
                    discard_d = 1'b0;
                    if (!discard_now) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus_ack_i ? bus_rdata_i : '0;
                    end
                end
            end

            ARB_DATA_BUSY: begin
                if (access_end) begin
                    state_d     = ARB_IDLE;
                    bus_req_d   = 1'b0;
                    bus_err_d   = ~bus_ack_i;
                    mem_ack_d   = 1'b1;
                    mem_rdata_d = (bus_ack_i && !bus_we_q) ? bus_rdata_i : '0;
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= GRANT_IF;
            discard_q    <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_sel_q    <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_err_q    <= 1'b0;
            if_ack_q     <= 1'b0;
            if_rdata_q   <= '0;
            mem_ack_q    <= 1'b0;
            mem_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            discard_q    <= discard_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_sel_q    <= bus_sel_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_err_q    <= bus_err_d;
            if_ack_q     <= if_ack_d;
            if_rdata_q   <= if_rdata_d;
            mem_ack_q    <= mem_ack_d;
            mem_rdata_q  <= mem_rdata_d;
        end
    end

    assign bus_req_o      = bus_req_q;
    assign bus_we_o       = bus_we_q;
    assign bus_sel_o      = bus_sel_q;
    assign bus_addr_o     = bus_addr_q;
    assign bus_wdata_o    = bus_wdata_q;
    assign bus_err_o      = bus_err_q;
    assign if_ack_o       = if_ack_q;
    assign if_rdata_o     = if_rdata_q;
    assign mem_ack_o      = mem_ack_q;
    assign mem_rdata_o    = mem_rdata_q;
    assign stallreq_if_o  = if_req_i  & ~if_ack_q;
    assign stallreq_mem_o = mem_req_i & ~mem_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requester scenarios push expected
// bus accesses and acks; independent monitors pop and compare.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int unsigned TB_TIMEOUT = 6;

    logic        clk;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        stallreq_if_o;
    logic        flush_i;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o;
    logic        stallreq_mem_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        bus_err_o;

    mem_arbiter #(
        .TIMEOUT (TB_TIMEOUT),
        .TO_W    (3)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_i       (if_req_i),
        .if_addr_i      (if_addr_i),
        .if_rdata_o     (if_rdata_o),
        .if_ack_o       (if_ack_o),
        .stallreq_if_o  (stallreq_if_o),
        .flush_i        (flush_i),
        .mem_req_i      (mem_req_i),
        .mem_we_i       (mem_we_i),
        .mem_sel_i      (mem_sel_i),
        .mem_addr_i     (mem_addr_i),
        .mem_wdata_i    (mem_wdata_i),
        .mem_rdata_o    (mem_rdata_o),
        .mem_ack_o      (mem_ack_o),
        .stallreq_mem_o (stallreq_mem_o),
        .bus_req_o      (bus_req_o),
        .bus_we_o       (bus_we_o),
        .bus_sel_o      (bus_sel_o),
        .bus_addr_o     (bus_addr_o),
        .bus_wdata_o    (bus_wdata_o),
        .bus_rdata_i    (bus_rdata_i),
        .bus_ack_i      (bus_ack_i),
        .bus_err_o      (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dur;
    } bus_exp_t;

    typedef struct {
        bit          is_mem;
        logic [31:0] rdata;
        bit          err;
    } ack_exp_t;

    bus_exp_t bus_q[$];
    ack_exp_t ack_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: acks after mem_wait extra cycles of bus_req_o, or never when hung.
    int mem_wait = 1;
    bit mem_hang = 1'b0;
    int wait_cnt = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h100) return 32'h3401_0020;
        return {a[15:0], 16'hC0DE};
    endfunction

    always @(negedge clk) begin
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'hBAD0_BAD0;
        if (rst || !bus_req_o || mem_hang) begin
            wait_cnt = 0;
        end else if (wait_cnt == mem_wait) begin
            bus_ack_i   = 1'b1;
            bus_rdata_i = mem_data(bus_addr_o);
            wait_cnt    = 0;
        end else begin
            wait_cnt++;
        end
    end

    // Bus monitor: command fields every busy cycle, and access length.
    bit       bus_active = 1'b0;
    bit       cur_ok     = 1'b0;
    bus_exp_t cur;
    int       cur_len    = 0;

    always @(negedge clk) begin
        if (rst) begin
            bus_active = 1'b0;
        end else if (bus_req_o) begin
            if (!bus_active) begin
                bus_active = 1'b1;
                cur_len    = 0;
                cur_ok     = (bus_q.size() != 0);
                if (cur_ok) begin
                    cur = bus_q.pop_front();
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: access to %h with none expected", bus_addr_o);
                end
            end
            cur_len++;
            if (cur_ok) begin
                check("bus_we",    {31'd0, bus_we_o}, {31'd0, cur.we});
                check("bus_sel",   {28'd0, bus_sel_o}, {28'd0, cur.sel});
                check("bus_addr",  bus_addr_o,  cur.addr);
                check("bus_wdata", bus_wdata_o, cur.wdata);
            end
        end else if (bus_active) begin
            bus_active = 1'b0;
            if (cur_ok && cur.dur != 0) check("bus_len", cur_len, cur.dur);
        end
    end

    // Return-path monitor.
    always @(negedge clk) begin
        if (!rst && (if_ack_o || mem_ack_o || bus_err_o)) begin
            if (ack_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ack_unexpected: if_ack=%b mem_ack=%b err=%b", if_ack_o, mem_ack_o, bus_err_o);
            end else begin
                ack_exp_t e;
                e = ack_q.pop_front();
                check("ack_owner", {30'd0, if_ack_o, mem_ack_o}, e.is_mem ? 32'd1 : 32'd2);
                check("ack_rdata", e.is_mem ? mem_rdata_o : if_rdata_o, e.rdata);
                check("ack_err",   {31'd0, bus_err_o}, {31'd0, e.err});
            end
        end
    end

    task automatic do_fetch(input logic [31:0] addr, output int lat);
        if_req_i  = 1'b1;
        if_addr_i = addr;
        lat       = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!if_ack_o) check("stallreq_if_busy", {31'd0, stallreq_if_o}, 32'd1);
        end while (!if_ack_o && lat < 60);
        check("if_ack_seen", {31'd0, if_ack_o}, 32'd1);
        check("stallreq_if_ack", {31'd0, stallreq_if_o}, 32'd0);
        if_req_i = 1'b0;
    endtask

    task automatic do_mem(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat);
        mem_req_i   = 1'b1;
        mem_we_i    = we;
        mem_sel_i   = sel;
        mem_addr_i  = addr;
        mem_wdata_i = wdata;
        lat         = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!mem_ack_o) check("stallreq_mem_busy", {31'd0, stallreq_mem_o}, 32'd1);
        end while (!mem_ack_o && lat < 60);
        check("mem_ack_seen", {31'd0, mem_ack_o}, 32'd1);
        check("stallreq_mem_ack", {31'd0, stallreq_mem_o}, 32'd0);
        mem_req_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bus_req"},   {31'd0, bus_req_o}, 32'd0);
        check({tag, "_bus_we"},    {31'd0, bus_we_o},  32'd0);
        check({tag, "_bus_sel"},   {28'd0, bus_sel_o}, 32'd0);
        check({tag, "_bus_addr"},  bus_addr_o,  32'd0);
        check({tag, "_bus_wdata"}, bus_wdata_o, 32'd0);
        check({tag, "_bus_err"},   {31'd0, bus_err_o}, 32'd0);
        check({tag, "_if_ack"},    {31'd0, if_ack_o},  32'd0);
        check({tag, "_mem_ack"},   {31'd0, mem_ack_o}, 32'd0);
        check({tag, "_if_rdata"},  if_rdata_o,  32'd0);
        check({tag, "_mem_rdata"}, mem_rdata_o, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL sim_timeout: bench did not finish");
        $fatal(1, "simulation time limit");
    end

    int lat_i;
    int lat_m;

    initial begin
        rst         = 1'b1;
        if_req_i    = 1'b0;
        if_addr_i   = '0;
        flush_i     = 1'b0;
        mem_req_i   = 1'b0;
        mem_we_i    = 1'b0;
        mem_sel_i   = '0;
        mem_addr_i  = '0;
        mem_wdata_i = '0;
        bus_rdata_i = '0;
        bus_ack_i   = 1'b0;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        check("reset_stallreq_if",  {31'd0, stallreq_if_o},  32'd0);
        check("reset_stallreq_mem", {31'd0, stallreq_mem_o}, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);

        // Fetch only, one wait cycle: three cycles request to ack.
        mem_wait = 1;
        bus_q.push_back('{1'b0, 4'hF, 32'h100, 32'h0, 2});
        ack_q.push_back('{1'b0, 32'h3401_0020, 1'b0});
        do_fetch(32'h100, lat_i);
        check("fetch_latency", lat_i, 3);
        repeat (2) @(negedge clk);
        check("fetch_single_access", {31'd0, bus_req_o}, 32'd0);

        // Contention after an IF grant: MEM store goes first.
        bus_q.push_back('{1'b1, 4'h3, 32'h8,   32'hAA55, 2});
        bus_q.push_back('{1'b0, 4'hF, 32'h104, 32'h0,    2});
        ack_q.push_back('{1'b1, 32'h0,         1'b0});
        ack_q.push_back('{1'b0, 32'h0104_C0DE, 1'b0});
        fork
            do_mem(1'b1, 4'h3, 32'h8, 32'hAA55, lat_m);
            do_fetch(32'h104, lat_i);
        join
        check("contend1_mem_lat", lat_m, 3);
        check("contend1_if_lat",  lat_i, 6);
        @(negedge clk);

        // Lone load leaves last_grant = MEM, then contention favours IF.
        bus_q.push_back('{1'b0, 4'hF, 32'h20, 32'h0, 2});
        ack_q.push_back('{1'b1, 32'h0020_C0DE, 1'b0});
        do_mem(1'b0, 4'hF, 32'h20, 32'h0, lat_m);
        @(negedge clk);
        bus_q.push_back('{1'b0, 4'hF, 32'h108, 32'h0,         2});
        bus_q.push_back('{1'b1, 4'hC, 32'hC,   32'h1234_5678, 2});
        ack_q.push_back('{1'b0, 32'h0108_C0DE, 1'b0});
        ack_q.push_back('{1'b1, 32'h0,         1'b0});
        fork
            do_mem(1'b1, 4'hC, 32'hC, 32'h1234_5678, lat_m);
            do_fetch(32'h108, lat_i);
        join
        check("contend2_if_lat",  lat_i, 3);
        check("contend2_mem_lat", lat_m, 6);
        @(negedge clk);

        // Five wait states: ack lands on the expiry cycle, ack wins; flush ignored in DATA_BUSY.
        mem_wait = 5;
        bus_q.push_back('{1'b0, 4'hF, 32'h40, 32'h0, 6});
        ack_q.push_back('{1'b1, 32'h0040_C0DE, 1'b0});
        fork
            do_mem(1'b0, 4'hF, 32'h40, 32'h0, lat_m);
            begin
                repeat (3) @(negedge clk);
                flush_i = 1'b1;
                @(negedge clk);
                flush_i = 1'b0;
            end
        join
        check("wait5_mem_lat", lat_m, 7);
        @(negedge clk);
        mem_wait = 1;
        bus_q.push_back('{1'b0, 4'hF, 32'h180, 32'h0, 2});
        ack_q.push_back('{1'b0, 32'h0180_C0DE, 1'b0});
        do_fetch(32'h180, lat_i);
        check("after_data_flush_lat", lat_i, 3);
        @(negedge clk);

        // Flush in IF_BUSY: first fetch discarded, retargeted fetch served.
        mem_wait = 2;
        bus_q.push_back('{1'b0, 4'hF, 32'h300, 32'h0, 3});
        bus_q.push_back('{1'b0, 4'hF, 32'h200, 32'h0, 3});
        ack_q.push_back('{1'b0, 32'h0200_C0DE, 1'b0});
        if_req_i  = 1'b1;
        if_addr_i = 32'h300;
        repeat (2) @(negedge clk);
        flush_i   = 1'b1;
        if_addr_i = 32'h200;
        @(negedge clk);
        flush_i = 1'b0;
        @(negedge clk);
        check("flush_no_ack",     {31'd0, if_ack_o}, 32'd0);
        check("flush_rdata_hold", if_rdata_o, 32'h0180_C0DE);
        lat_i = 0;
        while (!if_ack_o && lat_i < 60) begin
            @(negedge clk);
            lat_i++;
        end
        check("flush_refetch_lat", lat_i, 4);
        if_req_i = 1'b0;
        @(negedge clk);

        // Watchdog abort on a hung load.
        mem_hang = 1'b1;
        bus_q.push_back('{1'b0, 4'hF, 32'h60, 32'h0, 6});
        ack_q.push_back('{1'b1, 32'h0, 1'b1});
        do_mem(1'b0, 4'hF, 32'h60, 32'h0, lat_m);
        check("timeout_mem_lat", lat_m, 7);
        @(negedge clk);
        check("timeout_err_pulse", {31'd0, bus_err_o}, 32'd0);

        // Reset in the middle of a DATA_BUSY access.
        bus_q.push_back('{1'b1, 4'hF, 32'h80, 32'hCAFE, 0});
        mem_req_i   = 1'b1;
        mem_we_i    = 1'b1;
        mem_sel_i   = 4'hF;
        mem_addr_i  = 32'h80;
        mem_wdata_i = 32'hCAFE;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", {31'd0, bus_req_o}, 32'd1);
        #2 rst = 1'b1;
        #1 check_all_zero("midreset");
        mem_req_i = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        mem_hang = 1'b0;
        mem_wait = 1;
        @(negedge clk);

        // last_grant back to IF after reset, so MEM wins the tie.
        bus_q.push_back('{1'b1, 4'hF, 32'h84,  32'h5555_AAAA, 2});
        bus_q.push_back('{1'b0, 4'hF, 32'h10C, 32'h0,         2});
        ack_q.push_back('{1'b1, 32'h0,         1'b0});
        ack_q.push_back('{1'b0, 32'h010C_C0DE, 1'b0});
        fork
            do_mem(1'b1, 4'hF, 32'h84, 32'h5555_AAAA, lat_m);
            do_fetch(32'h10C, lat_i);
        join
        check("post_reset_mem_lat", lat_m, 3);
        check("post_reset_if_lat",  lat_i, 6);

        repeat (3) @(negedge clk);
        check("bus_queue_drained", bus_q.size(), 0);
        check("ack_queue_drained", ack_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
